// File: rtl/serial_adder_n_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared types and helpers for the digit-serial adder/subtractor:
//               FSM state encoding and digit-counter width calculation.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter wide enough to hold WIDTH/DIGIT digit indices plus one spare bit.
    function automatic int cnt_width(input int width, input int digit);
        return $clog2(width / digit) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_n_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_n_if
// Description : Request/result bundle between a requester (master) and the
//               digit-serial adder (slave). The ovf signal exists only when
//               SERIAL_ADDER_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_adder_n_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
        , output ovf
`endif
    );
endinterface
`default_nettype wire

// File: rtl/serial_adder_n_fa_cell.sv
`default_nettype none
// ============================================================================
// Module      : fa_cell
// Description : 1-bit combinational full adder, one link of the ripple chain.
// Revision    : 1.0 - initial release
// ============================================================================
module fa_cell (
    input  wire logic a,
    input  wire logic b,
    input  wire logic cin,
    output logic      s,
    output logic      c
);
    assign s = a ^ b ^ cin;
    assign c = (a & b) | (cin & (a ^ b));
endmodule
`default_nettype wire

// File: rtl/serial_adder_n.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_n
// Description : Multi-cycle adder/subtractor processing DIGIT bits per clock
//               through a ripple chain of fa_cell, carry held in a flop
//               between digits. Subtraction is a + ~b + ~cin.
//               Optional macro SERIAL_ADDER_OVF_EN adds the signed-overflow
//               output and its MSB carry-in tap.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_n
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    serial_adder_n_if.slave  bus
);
    localparam int              c_num_digits = WIDTH / DIGIT;
    localparam int              c_cnt_w      = cnt_width(WIDTH, DIGIT);
    localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(c_num_digits - 1);

    // Reject configurations the digit chain cannot represent.
    generate
        if ((WIDTH % DIGIT) != 0 || WIDTH < 2) begin : g_param_check
            $fatal(1, "serial_adder_n: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     r_a_sh;
    logic [WIDTH-1:0]     r_b_sh;
    logic [WIDTH-1:0]     r_p;
    logic [WIDTH-1:0]     r_sum;
    logic                 r_c;
    logic                 r_cout;
    logic                 r_pend;
    logic [c_cnt_w-1:0]   r_cnt;

    logic [DIGIT:0]       w_carry;
    logic [DIGIT-1:0]     w_s;
    logic [WIDTH-1:0]     w_p_next;
    logic                 w_step;
    logic                 w_last;
    logic                 w_load;
    logic                 w_busy;
    logic                 w_done;

    // Ripple chain over the low DIGIT bits of the operand shift registers.
    assign w_carry[0] = r_c;
    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_chain
            fa_cell u_fa (
                .a   (r_a_sh[i]),
                .b   (r_b_sh[i]),
                .cin (w_carry[i]),
                .s   (w_s[i]),
                .c   (w_carry[i+1])
            );
        end
    endgenerate

    // New digit enters P from the MSB end, so after N digits P holds the sum.
    generate
        if (DIGIT == WIDTH) begin : g_p_single
            assign w_p_next = w_s;
        end else begin : g_p_shift
            assign w_p_next = {w_s, r_p[WIDTH-1:DIGIT]};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state and control decode. A start seen on the completing digit is
    // taken as a back-to-back request: its first digit is processed during the
    // DONE cycle (r_pend), which keeps throughput at one result per N cycles.
    always_comb begin
        w_state_next = r_state;
        w_step       = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) w_state_next = RUN;
            end
            RUN: begin
                w_busy = 1'b1;
                w_step = 1'b1;
                if (r_cnt == c_last) w_state_next = DONE;
            end
            DONE: begin
                w_done = 1'b1;
                if (r_pend) begin
                    w_step       = 1'b1;
                    w_state_next = (r_cnt == c_last) ? DONE : RUN;
                end else if (bus.start) begin
                    w_state_next = RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
        w_last = w_step && (r_cnt == c_last);
        w_load = bus.start && ((r_state == IDLE) ||
                               ((r_state == DONE) && !r_pend) ||
                               w_last);
    end

    // Operand shifters, carry flop, digit counter and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_p    <= '0;
            r_c    <= 1'b0;
            r_cnt  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            if (w_load) begin
                r_a_sh <= bus.a;
                r_b_sh <= bus.b ^ {WIDTH{bus.sub}};
                r_c    <= bus.cin ^ bus.sub;
                r_cnt  <= '0;
                r_p    <= '0;
            end else if (w_step) begin
                r_a_sh <= r_a_sh >> DIGIT;
                r_b_sh <= r_b_sh >> DIGIT;
                r_c    <= w_carry[DIGIT];
                r_cnt  <= r_cnt + 1'b1;
                r_p    <= w_p_next;
            end
            if (w_last) begin
                r_sum  <= w_p_next;
                r_cout <= w_carry[DIGIT];
            end
            r_pend <= w_load && w_last;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_ovf <= 1'b0;
        else if (w_last) r_ovf <= w_carry[DIGIT] ^ w_carry[DIGIT-1];
    end

    assign bus.ovf = r_ovf;
`endif

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder_n
// Description : Self-checking bench for serial_adder_n. One instance with
//               DIGIT=1 and one with DIGIT=4 (both WIDTH=8). Expected results
//               come from a hand-derived vector table and are queued per
//               instance at issue time, then compared when done pulses.
//               ovf is checked only when SERIAL_ADDER_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_n;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         edge_no;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t q1[$];
    exp_t q4[$];

    serial_adder_n_if #(.WIDTH(8)) bus1 ();
    serial_adder_n_if #(.WIDTH(8)) bus4 ();

    serial_adder_n #(.WIDTH(8), .DIGIT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    serial_adder_n #(.WIDTH(8), .DIGIT(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    always #5 clk = ~clk;

    // Rising-edge counter: after edge k (sampled away from the edge) cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Result monitor, DIGIT=1 instance.
    always @(negedge clk) begin : mon1
        exp_t e;
        if (bus1.done === 1'b1) begin
            if (q1.size() == 0) begin
                check("d1 spurious done", bus1.done, 0);
            end else begin
                e = q1.pop_front();
                check("d1 sum", bus1.sum, e.sum);
                check("d1 cout", bus1.cout, e.cout);
`ifdef SERIAL_ADDER_OVF_EN
                check("d1 ovf", bus1.ovf, e.ovf);
`endif
                check("d1 done edge", cyc, e.edge_no);
                check("d1 busy at done", bus1.busy, 0);
            end
        end
    end

    // Result monitor, DIGIT=4 instance.
    always @(negedge clk) begin : mon4
        exp_t e;
        if (bus4.done === 1'b1) begin
            if (q4.size() == 0) begin
                check("d4 spurious done", bus4.done, 0);
            end else begin
                e = q4.pop_front();
                check("d4 sum", bus4.sum, e.sum);
                check("d4 cout", bus4.cout, e.cout);
`ifdef SERIAL_ADDER_OVF_EN
                check("d4 ovf", bus4.ovf, e.ovf);
`endif
                check("d4 done edge", cyc, e.edge_no);
            end
        end
    end

    // Drive one request on the DIGIT=1 instance; optionally queue its result.
    task automatic issue1(input vec_t v, input bit expect_result);
        exp_t e;
        @(posedge clk); #1;
        bus1.a     = v.a;
        bus1.b     = v.b;
        bus1.cin   = v.cin;
        bus1.sub   = v.sub;
        bus1.start = 1'b1;
        e.sum = v.sum; e.cout = v.cout; e.ovf = v.ovf; e.edge_no = cyc + 1 + 8;
        if (expect_result) q1.push_back(e);
        @(posedge clk); #1;
        bus1.start = 1'b0;
        check("d1 busy after start", bus1.busy, 1);
    endtask

    task automatic drain(input int which);
        int k = 0;
        while (((which == 1) ? q1.size() : q4.size()) != 0 && k < 40) begin
            @(posedge clk);
            k++;
        end
        check((which == 1) ? "d1 result timeout" : "d4 result timeout",
              (which == 1) ? q1.size() : q4.size(), 0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        vec_t tbl[10];
        vec_t v;
        exp_t e;
        int   e0;

        tbl[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        tbl[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        tbl[4] = '{8'h3C, 8'h45, 1'b1, 1'b0, 8'h82, 1'b0, 1'b1};
        tbl[5] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[6] = '{8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[7] = '{8'h10, 8'h20, 1'b1, 1'b1, 8'hEF, 1'b0, 1'b0};
        tbl[8] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
        tbl[9] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};

        rst = 1'b1;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.sub = 1'b0;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset d1 busy", bus1.busy, 0);
        check("reset d1 done", bus1.done, 0);
        check("reset d1 sum", bus1.sum, 0);
        check("reset d1 cout", bus1.cout, 0);
        check("reset d4 busy", bus4.busy, 0);
        check("reset d4 sum", bus4.sum, 0);
`ifdef SERIAL_ADDER_OVF_EN
        check("reset d1 ovf", bus1.ovf, 0);
`endif
        #3 rst = 1'b0;

        // Table-driven vectors on the bit-serial instance.
        for (int i = 0; i < 10; i++) begin
            issue1(tbl[i], 1'b1);
            check("d1 sum held during run", bus1.sum, (i == 0) ? 8'h00 : tbl[i-1].sum);
            drain(1);
        end

        // Second start mid-run with different operands must be ignored.
        issue1(tbl[0], 1'b1);
        @(posedge clk); #1;
        bus1.a = 8'hFF; bus1.b = 8'hFF; bus1.cin = 1'b1; bus1.sub = 1'b1;
        bus1.start = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        check("d1 busy after ignored start", bus1.busy, 1);
        drain(1);
        repeat (4) @(posedge clk);
        #1;
        check("d1 sum holds after ignored start", bus1.sum, 8'h80);
        check("d1 idle after ignored start", bus1.busy, 0);

        // Asynchronous reset mid-run discards the operation and clears outputs.
        v = '{8'h3C, 8'h45, 1'b1, 1'b0, 8'h82, 1'b0, 1'b1};
        issue1(v, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst d1 sum", bus1.sum, 0);
        check("async rst d1 cout", bus1.cout, 0);
        check("async rst d1 busy", bus1.busy, 0);
        check("async rst d1 done", bus1.done, 0);
`ifdef SERIAL_ADDER_OVF_EN
        check("async rst d1 ovf", bus1.ovf, 0);
`endif
        @(posedge clk);
        #3 rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("d1 idle after reset", bus1.busy, 0);
        v = '{8'h21, 8'h13, 1'b0, 1'b0, 8'h34, 1'b0, 1'b0};
        issue1(v, 1'b1);
        drain(1);

        // DIGIT=4: two-cycle latency, back-to-back start on the completing
        // edge, then a start taken from the DONE cycle.
        @(posedge clk); #1;
        e0 = cyc + 1;
        bus4.a = 8'h9C; bus4.b = 8'h6A; bus4.cin = 1'b1; bus4.sub = 1'b0;
        bus4.start = 1'b1;
        e.sum = 8'h07; e.cout = 1'b1; e.ovf = 1'b0; e.edge_no = e0 + 2;
        q4.push_back(e);
        @(posedge clk); #1;
        bus4.start = 1'b0;
        check("d4 busy after start", bus4.busy, 1);
        @(posedge clk); #1;
        bus4.a = 8'h12; bus4.b = 8'h34; bus4.cin = 1'b0; bus4.sub = 1'b0;
        bus4.start = 1'b1;
        e.sum = 8'h46; e.cout = 1'b0; e.ovf = 1'b0; e.edge_no = e0 + 4;
        q4.push_back(e);
        @(posedge clk); #1;
        bus4.start = 1'b0;
        check("d4 busy low at completion", bus4.busy, 0);
        @(posedge clk); #1;
        check("d4 sum held during back-to-back", bus4.sum, 8'h07);
        @(posedge clk); #1;
        bus4.a = 8'h7F; bus4.b = 8'h7F; bus4.cin = 1'b0; bus4.sub = 1'b0;
        bus4.start = 1'b1;
        e.sum = 8'hFE; e.cout = 1'b0; e.ovf = 1'b1; e.edge_no = e0 + 7;
        q4.push_back(e);
        @(posedge clk); #1;
        bus4.start = 1'b0;
        drain(4);
        repeat (4) @(posedge clk);
        #1;
        check("d4 idle at end", bus4.busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
